// File: rtl/qdi_rx_arbiter.sv
// Round-robin arbiter that collects e1of3 tokens from NCH QDI channels and
// presents them one at a time on a clocked valid/ready port, driving each Le return.
module qdi_rx_arbiter #(
    parameter int NCH    = 4,
    parameter int CW     = 2,
    parameter int SYNC   = 2,
    parameter int TO_CYC = 1024,
    parameter int TOW    = 11
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [3*NCH-1:0]   L,
    output logic [NCH-1:0]     Le,
    output logic [1:0]         dout,
    output logic [CW-1:0]      chan,
    output logic               valid,
    input  logic               ready,
    output logic [NCH-1:0]     err,
    output logic               timeout,
    inout  wire                VDD,
    inout  wire                GND
);
    localparam int IW = $clog2(NCH);

    typedef enum logic [1:0] {INIT, IDLE, OFFER, WAIT_NEUTRAL} state_t;

    state_t             state, state_nxt;
    logic [3*NCH-1:0]   rail_sync [SYNC];
    logic [3*NCH-1:0]   rail_prev;
    logic [2:0]         code [NCH];
    logic [NCH-1:0]     pend, bad, neutral, mask;
    logic [CW-1:0]      ptr, gnt, gsel;
    logic               found;
    logic [TOW-1:0]     timer;

    // Supplies are carried through for netlist compatibility only.
    wire supply_unused = VDD & GND;

    function automatic logic is_onehot(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    function automatic logic [1:0] decode(input logic [2:0] v);
        case (v)
            3'b010:  return 2'b01;
            3'b100:  return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [CW-1:0] next_ptr(input logic [CW-1:0] g);
        return (g == CW'(NCH - 1)) ? '0 : g + 1'b1;
    endfunction

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < SYNC; i++) rail_sync[i] <= '0;
            rail_prev <= '0;
        end else begin
            rail_sync[0] <= L;
            for (int i = 1; i < SYNC; i++) rail_sync[i] <= rail_sync[i-1];
            rail_prev <= rail_sync[SYNC-1];
        end
    end

    // A code only counts once it has held for two cycles; rail skew reads as neutral.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            code[k]    = (rail_sync[SYNC-1][3*k +: 3] == rail_prev[3*k +: 3])
                         ? rail_sync[SYNC-1][3*k +: 3] : 3'b000;
            neutral[k] = (code[k] == 3'b000);
            pend[k]    = Le[k] && !mask[k] && is_onehot(code[k]);
            bad[k]     = Le[k] && !neutral[k] && !is_onehot(code[k]);
        end
    end

    always_comb begin
        found = 1'b0;
        gsel  = '0;
        for (int i = 0; i < NCH; i++) begin
            int idx;
            idx = (int'(ptr) + i) % NCH;
            if (!found && pend[idx[IW-1:0]]) begin
                found = 1'b1;
                gsel  = CW'(idx);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:         state_nxt = IDLE;
            IDLE:         if (found) state_nxt = OFFER;
            OFFER:        if (ready) state_nxt = WAIT_NEUTRAL;
            WAIT_NEUTRAL: if (neutral[gnt]) state_nxt = IDLE;
            default:      state_nxt = INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Le      <= '0;
            valid   <= 1'b0;
            dout    <= '0;
            chan    <= '0;
            err     <= '0;
            timeout <= 1'b0;
            ptr     <= '0;
            gnt     <= '0;
            mask    <= '0;
            timer   <= '0;
        end else begin
            mask <= (mask | ((state == IDLE) ? bad : '0)) & ~neutral;
            case (state)
                INIT: Le <= '1;
                IDLE: begin
                    err <= err | bad;
                    if (found) begin
                        dout  <= decode(code[gsel]);
                        chan  <= gsel;
                        gnt   <= gsel;
                        valid <= 1'b1;
                    end
                end
                OFFER: begin
                    if (ready) begin
                        valid   <= 1'b0;
                        Le[gnt] <= 1'b0;
                        ptr     <= next_ptr(gnt);
                        timer   <= '0;
                    end
                end
                WAIT_NEUTRAL: begin
                    if (neutral[gnt]) Le[gnt] <= 1'b1;
                    if (timer != TOW'(TO_CYC)) timer <= timer + 1'b1;
                    if (timer == TOW'(TO_CYC - 1)) timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_qdi_rx_arbiter.sv
// Scoreboard bench for qdi_rx_arbiter: directed handshakes plus random token batches
// whose grant order is predicted from the round-robin rule.
module tb_qdi_rx_arbiter;
    localparam int NCH = 4, CW = 2, SYNC = 2, TO_CYC = 1024;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [3*NCH-1:0]   l_rails;
    logic [NCH-1:0]     le;
    logic [1:0]         dout;
    logic [CW-1:0]      chan;
    logic               valid;
    logic               ready;
    logic [NCH-1:0]     err;
    logic               timeout;
    wire                vdd = 1'b1;
    wire                gnd = 1'b0;

    int                 checks = 0, errors = 0;
    logic [CW+1:0]      exp_q [$];
    logic [NCH-1:0]     active;
    logic               rand_ready;
    int                 model_ptr;

    qdi_rx_arbiter dut (
        .CLK(clk), .RESET(rst_n), .L(l_rails), .Le(le), .dout(dout), .chan(chan),
        .valid(valid), .ready(ready), .err(err), .timeout(timeout), .VDD(vdd), .GND(gnd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] rail_value(input logic [2:0] r);
        if (r == 3'b001) return 2'd0;
        if (r == 3'b010) return 2'd1;
        return 2'd2;
    endfunction

    // Each tick also plays the QDI source: a channel whose Le fell returns to neutral.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < NCH; k++) begin
            if (active[k] && !le[k]) begin
                l_rails[3*k +: 3] = 3'b000;
                active[k] = 1'b0;
            end
        end
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_drain(input string name, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (active == '0 && le == '1 && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic run_batch(input logic [3*NCH-1:0] lv, input string name);
        int last;
        last = -1;
        for (int i = 0; i < NCH; i++) begin
            int k;
            k = (model_ptr + i) % NCH;
            if (lv[3*k +: 3] != 3'b000) begin
                exp_q.push_back({CW'(k), rail_value(lv[3*k +: 3])});
                last = k;
            end
        end
        for (int k = 0; k < NCH; k++) active[k] = (lv[3*k +: 3] != 3'b000);
        l_rails = lv;
        wait_drain(name, 300);
        if (last >= 0) model_ptr = (last + 1) % NCH;
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        model_ptr = 0;
        check("le_after_reset_pulse", 32'(le), 32'hF);
    endtask

    task automatic monitor();
        logic [CW+1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && valid && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_token: got chan=%0d dout=%0d, want none", chan, dout);
                end else begin
                    e = exp_q.pop_front();
                    check("token", 32'({chan, dout}), 32'(e));
                end
            end
        end
    endtask

    task automatic stimulus();
        int vcount;
        logic ok;
        logic [3*NCH-1:0] lv;
        logic [1:0] held_dout;
        logic [CW-1:0] held_chan;

        rst_n = 1'b0; l_rails = '0; ready = 1'b0; active = '0;
        rand_ready = 1'b0; model_ptr = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_le", 32'(le), 32'h0);
        check("reset_outputs", 32'({valid, dout, chan, err, timeout}), 32'h0);
        rst_n = 1'b1;
        check("le_before_init", 32'(le), 32'h0);
        tick();
        check("le_after_init", 32'(le), 32'hF);

        // Single token on channel 2, latency and Le return
        ready = 1'b1;
        exp_q.push_back({2'd2, 2'b01});
        active[2] = 1'b1;
        l_rails[8:6] = 3'b010;
        repeat (SYNC + 1) tick();
        check("latency_early", 32'(valid), 32'd0);
        tick();
        check("latency_valid", 32'(valid), 32'd1);
        tick();
        check("single_le_low", 32'({le[2], valid}), 32'd0);
        ok = 1'b0;
        for (int i = 0; i < SYNC + 2; i++) begin
            tick();
            if (le[2]) begin ok = 1'b1; break; end
        end
        check("single_le_return", 32'(ok), 32'd1);
        check("single_popped", 32'(exp_q.size()), 32'd0);
        model_ptr = 3;

        reset_pulse();
        run_batch(12'b010_000_100_001, "contention");

        // Backpressure with a rail change on the granted channel during the offer
        ready = 1'b0;
        exp_q.push_back({2'd1, 2'b10});
        active[1] = 1'b1;
        l_rails[5:3] = 3'b100;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid) begin ok = 1'b1; break; end
        end
        check("bp_valid", 32'(ok), 32'd1);
        held_dout = dout;
        held_chan = chan;
        check("bp_offer", 32'({held_chan, held_dout}), 32'({2'd1, 2'b10}));
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 5) l_rails[5:3] = 3'b001;
            check("bp_hold", 32'({valid, chan, dout, le[1]}), 32'({1'b1, held_chan, held_dout, 1'b1}));
        end
        ready = 1'b1;
        wait_drain("bp_drain", 50);
        model_ptr = 2;

        // Stable multi-rail code on channel 1
        l_rails[5:3] = 3'b011;
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (valid) vcount++;
        end
        check("bad_err", 32'(err), 32'b0010);
        check("bad_no_valid", 32'(vcount), 32'd0);
        l_rails[5:3] = 3'b000;
        repeat (4) tick();
        exp_q.push_back({2'd1, 2'b10});
        active[1] = 1'b1;
        l_rails[5:3] = 3'b100;
        wait_drain("bad_then_served", 50);
        check("bad_err_sticky", 32'(err), 32'b0010);
        model_ptr = 2;

        rand_ready = 1'b1;
        for (int b = 0; b < 30; b++) begin
            lv = '0;
            for (int k = 0; k < NCH; k++)
                if ($urandom_range(0, 1) == 1) lv[3*k +: 3] = 3'(3'b001 << $urandom_range(0, 2));
            run_batch(lv, "random_batch");
        end
        rand_ready = 1'b0;
        ready = 1'b1;

        // Granted channel that never returns to neutral, then reset mid-wait
        reset_pulse();
        check("reset_pulse_err", 32'(err), 32'h0);
        exp_q.push_back({2'd0, 2'b00});
        l_rails[2:0] = 3'b001;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!le[0]) begin ok = 1'b1; break; end
        end
        check("to_granted", 32'(ok), 32'd1);
        repeat (1000) tick();
        check("to_not_yet", 32'(timeout), 32'd0);
        check("to_waiting", 32'({le[0], valid}), 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (timeout) begin ok = 1'b1; break; end
        end
        check("to_flagged", 32'(ok), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midwait_reset_le", 32'(le), 32'h0);
        check("midwait_reset_outputs", 32'({valid, dout, chan, err, timeout}), 32'h0);
        l_rails = '0;
        tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic watchdog();
        repeat (40000) @(posedge clk);
        $display("FAIL watchdog: got no completion, want completion within 40000 cycles");
        $fatal(1, "bench stalled");
    endtask

    initial begin
        fork
            monitor();
            stimulus();
            watchdog();
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
